// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues credit-limited word requests,
// buffers in-order responses in a small FIFO and hands {pc, instruction} pairs to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [OW-1:0] out_cnt;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  logic [31:0] credit;
  logic        req_fire;
  logic        rsp_ok;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc_aligned;

  // Slots already promised to in-flight kept responses plus slots occupied.
  assign credit = 32'(out_cnt) - 32'(drop_cnt) + 32'(fifo_cnt);

  assign imem_req_valid_o = !rst_i && !redirect_i &&
                            (out_cnt < OW'(MAX_OUTSTANDING)) &&
                            (credit < 32'(FIFO_DEPTH));
  assign imem_addr_o      = pc_q;

  assign instr_valid_o = (fifo_cnt != '0) && !redirect_i;
  assign instruction_o = fifo_instr[rd_ptr];
  assign pc_o          = fifo_pc[rd_ptr];

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok   = imem_rsp_valid_i && (out_cnt != '0);
  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign push     = rsp_ok && (drop_cnt == '0) && !redirect_i;
  assign pop      = instr_valid_o && instr_ready_i;

  assign redirect_pc_aligned = redirect_pc_i & ~32'h3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_i) begin
      // Everything still in flight becomes a response to throw away.
      pc_q     <= redirect_pc_aligned;
      rsp_pc_q <= redirect_pc_aligned;
      out_cnt  <= rsp_ok ? out_cnt - OW'(1) : out_cnt;
      drop_cnt <= rsp_ok ? out_cnt - OW'(1) : out_cnt;
      fifo_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
      if (req_fire && !rsp_ok) begin
        out_cnt <= out_cnt + OW'(1);
      end else if (!req_fire && rsp_ok) begin
        out_cnt <= out_cnt - OW'(1);
      end
      if (rsp_ok && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - OW'(1);
      end
      if (push) begin
        rsp_pc_q <= rsp_pc_q + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  // Storage is cleared on reset so decode sees zeros until the first push.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        fifo_pc[gi]    <= '0;
        fifo_instr[gi] <= '0;
      end else if (push && (wr_ptr == PW'(gi))) begin
        fifo_pc[gi]    <= rsp_pc_q;
        fifo_instr[gi] <= imem_rsp_data_i;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table with hand-computed
// expectations, plus hand-written reset sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .RESET_PC       (32'h0000_0100),
    .FIFO_DEPTH     (2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instruction_o   (instruction_o),
    .pc_o            (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        er;
    logic [31:0] ea;
    logic        ei;
    logic [31:0] eins;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic rr,
                     input logic rv, input logic [31:0] rd, input logic ir,
                     input logic er, input logic [31:0] ea, input logic ei,
                     input logic [31:0] eins, input logic [31:0] epc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
    v.er = er; v.ea = ea; v.ei = ei; v.eins = eins; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rr,
                       input logic rv, input logic [31:0] rd, input logic ir);
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = rr;
    imem_rsp_valid_i = rv;
    imem_rsp_data_i  = rd;
    instr_ready_i    = ir;
  endtask

  initial begin
    // redir rpc rr rv rd ir | req_valid addr instr_valid instruction pc
    // Reset start: two requests accepted, memory silent.
    add(0, 0, 1, 0, 0, 1,  1, 32'h100, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  1, 32'h104, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  0, 32'h108, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  0, 32'h108, 0, 0, 0);
    // Responses arrive; decode always ready.
    add(0, 0, 1, 1, 32'h00500093, 1,  0, 32'h108, 0, 0, 0);
    add(0, 0, 1, 1, 32'h00100113, 1,  0, 32'h108, 1, 32'h00500093, 32'h100);
    add(0, 0, 1, 0, 0, 1,  1, 32'h108, 1, 32'h00100113, 32'h104);
    add(0, 0, 1, 1, 32'h00208193, 1,  1, 32'h10C, 0, 0, 0);
    add(0, 0, 1, 1, 32'h00308213, 1,  0, 32'h110, 1, 32'h00208193, 32'h108);
    add(0, 0, 1, 0, 0, 1,  1, 32'h110, 1, 32'h00308213, 32'h10C);
    // Backpressure from decode: FIFO fills, fetch stalls, head holds.
    add(0, 0, 1, 1, 32'hAA000110, 0,  1, 32'h114, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000114, 0,  0, 32'h118, 1, 32'hAA000110, 32'h110);
    add(0, 0, 1, 0, 0, 0,  0, 32'h118, 1, 32'hAA000110, 32'h110);
    add(0, 0, 1, 0, 0, 0,  0, 32'h118, 1, 32'hAA000110, 32'h110);
    add(0, 0, 1, 0, 0, 1,  0, 32'h118, 1, 32'hAA000110, 32'h110);
    add(0, 0, 1, 0, 0, 1,  1, 32'h118, 1, 32'hAA000114, 32'h114);
    add(0, 0, 1, 1, 32'hAA000118, 1,  1, 32'h11C, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  0, 32'h120, 1, 32'hAA000118, 32'h118);
    add(0, 0, 1, 0, 0, 1,  1, 32'h120, 0, 0, 0);
    // Redirect with two in flight: both stale responses are dropped.
    add(1, 32'h203, 1, 0, 0, 1,  0, 32'h124, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA00011C, 1,  0, 32'h200, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000120, 1,  1, 32'h200, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000200, 1,  1, 32'h204, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000204, 1,  0, 32'h208, 1, 32'hAA000200, 32'h200);
    add(0, 0, 0, 0, 0, 1,  1, 32'h208, 1, 32'hAA000204, 32'h204);
    // Redirect colliding with a response, req_ready and instr_ready.
    add(0, 0, 1, 0, 0, 1,  1, 32'h208, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000208, 1,  1, 32'h20C, 0, 0, 0);
    add(1, 32'h300, 1, 1, 32'hAA00020C, 1,  0, 32'h210, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  1, 32'h300, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000300, 1,  1, 32'h304, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  0, 32'h308, 1, 32'hAA000300, 32'h300);
    // Back-to-back redirects (last wins), then a stalled fetch that wraps.
    add(1, 32'h12345, 1, 0, 0, 1,  0, 32'h308, 0, 0, 0);
    add(1, 32'hFFFFFFFE, 1, 1, 32'hAA000304, 1,  0, 32'h12344, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 32'hFFFFFFFC, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 32'hFFFFFFFC, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1,  1, 32'hFFFFFFFC, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 32'h00000000, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000FFC, 1,  1, 32'h00000000, 0, 0, 0);
    add(0, 0, 1, 1, 32'hAA000000, 1,  0, 32'h4, 1, 32'hAA000FFC, 32'hFFFFFFFC);
    add(0, 0, 0, 0, 0, 1,  1, 32'h4, 1, 32'hAA000000, 32'h00000000);
    // Response with nothing outstanding must be ignored.
    add(0, 0, 0, 1, 32'hDEADBEEF, 1,  1, 32'h4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 32'h4, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_req_valid", -1, 32'(imem_req_valid_o), 32'd0);
    chk("reset_addr", -1, imem_addr_o, 32'h100);
    chk("reset_instr_valid", -1, 32'(instr_valid_o), 32'd0);
    chk("reset_instruction", -1, instruction_o, 32'd0);
    chk("reset_pc", -1, pc_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir);
      #1;
      $display("row %0d: redir=%0b rsp=%0b req_valid=%0b addr=%h instr_valid=%0b instr=%h pc=%h",
               i, vecs[i].redir, vecs[i].rv, imem_req_valid_o, imem_addr_o,
               instr_valid_o, instruction_o, pc_o);
      chk("req_valid", i, 32'(imem_req_valid_o), 32'(vecs[i].er));
      chk("addr", i, imem_addr_o, vecs[i].ea);
      chk("instr_valid", i, 32'(instr_valid_o), 32'(vecs[i].ei));
      if (vecs[i].ei) begin
        chk("instruction", i, instruction_o, vecs[i].eins);
        chk("pc", i, pc_o, vecs[i].epc);
      end
      @(negedge clk);
    end

    // Mid-operation asynchronous reset: fetch 0x4, buffer it, then reset.
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("mid_req_valid", 100, 32'(imem_req_valid_o), 32'd1);
    @(negedge clk);
    drive(0, 0, 1, 1, 32'hAA000004, 0);
    #1;
    chk("mid_addr", 101, imem_addr_o, 32'h8);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("mid_instr_valid", 102, 32'(instr_valid_o), 32'd1);
    chk("mid_pc", 102, pc_o, 32'h4);
    #1;
    rst_i = 1'b1;
    #1;
    $display("async reset asserted mid-cycle: req_valid=%0b addr=%h instr_valid=%0b instr=%h pc=%h",
             imem_req_valid_o, imem_addr_o, instr_valid_o, instruction_o, pc_o);
    chk("arst_req_valid", 103, 32'(imem_req_valid_o), 32'd0);
    chk("arst_addr", 103, imem_addr_o, 32'h100);
    chk("arst_instr_valid", 103, 32'(instr_valid_o), 32'd0);
    chk("arst_instruction", 103, instruction_o, 32'd0);
    chk("arst_pc", 103, pc_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("post_rst_req_valid", 104, 32'(imem_req_valid_o), 32'd1);
    chk("post_rst_addr", 104, imem_addr_o, 32'h100);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
